// File: rtl/usfft_pkg.sv
// usfft_pkg: shared state encoding, LFSR tap table and twiddle addressing for the stochastic FFT.
package usfft_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  // Fibonacci taps (shift left, parity of tapped bits into bit 0), maximal length per width
  function automatic logic [31:0] lfsr_taps(input int w);
    case (w)
      2: return 32'h0003;
      3: return 32'h0006;
      4: return 32'h000C;
      5: return 32'h0014;
      6: return 32'h0030;
      7: return 32'h0060;
      8: return 32'h00B8;
      9: return 32'h0110;
      10: return 32'h0240;
      11: return 32'h0500;
      12: return 32'h0829;
      13: return 32'h100D;
      14: return 32'h2015;
      15: return 32'h6000;
      default: return 32'hD008;
    endcase
  endfunction
  function automatic int tw_addr(input int stage, input int bfly, input int n);
    return stage * (n / 2) + bfly;
  endfunction
endpackage

// File: rtl/usfft_bfly.sv
// usfft_bfly: one bipolar-bitstream radix-2 butterfly with a stochastic twiddle and registered outputs.
module usfft_bfly #(
  parameter int BITWIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [1:0]            sel,
  input  logic [BITWIDTH-1:0]   rng,
  input  logic [BITWIDTH-1:0]   rng_r,
  input  logic [2*BITWIDTH-1:0] tw,
  input  logic                  x0r,
  input  logic                  x0i,
  input  logic                  x1r,
  input  logic                  x1i,
  output logic                  y0r,
  output logic                  y0i,
  output logic                  y1r,
  output logic                  y1i,
  output logic                  valid
);
  logic wr, wi, tr, ti;
  always_comb begin
    wr = rng < tw[BITWIDTH-1:0];
    wi = rng_r < tw[2*BITWIDTH-1:BITWIDTH];
    tr = sel[1] ? ~(x1r ^ wr) : (x1i ^ wi);
    ti = sel[1] ? ~(x1r ^ wi) : ~(x1i ^ wr);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {y0r, y0i, y1r, y1i, valid} <= '0;
    end else begin
      valid <= en;
      y0r <= en & (sel[0] ? x0r : tr);
      y1r <= en & (sel[0] ? x0r : ~tr);
      y0i <= en & (sel[0] ? x0i : ti);
      y1i <= en & (sel[0] ? x0i : ~ti);
    end
endmodule

// File: rtl/usfft_stream.sv
// usfft_stream: streaming stochastic-bitstream FFT with loadable twiddles and per-channel ones counters.
module usfft_stream
  import usfft_pkg::*;
#(
  parameter int BITWIDTH = 8,
  parameter int NUMINPUTS = 8,
  parameter int CYCLES = 256,
  localparam int LOG2N = $clog2(NUMINPUTS),
  localparam int TWA = $clog2(NUMINPUTS / 2 * LOG2N),
  localparam int CW = $clog2(CYCLES + 1)
) (
  input  logic                    iClk,
  input  logic                    iRstN,
  input  logic                    iStart,
  input  logic                    iTwValid,
  input  logic [TWA-1:0]          iTwAddr,
  input  logic [2*BITWIDTH-1:0]   iTwData,
  input  logic [NUMINPUTS-1:0]    iReal,
  input  logic [NUMINPUTS-1:0]    iImg,
  output logic                    oTwReady,
  output logic                    oBusy,
  output logic                    oDone,
  output logic [NUMINPUTS-1:0]    oReal,
  output logic [NUMINPUTS-1:0]    oImg,
  output logic [NUMINPUTS*CW-1:0] oCntReal,
  output logic [NUMINPUTS*CW-1:0] oCntImg
);
  localparam int NTW = NUMINPUTS / 2 * LOG2N;
  localparam logic [BITWIDTH-1:0] TAPS = BITWIDTH'(lfsr_taps(BITWIDTH));
  state_t state, nxt;
  logic [CW-1:0] tmr;
  logic [1:0] cnt;
  logic [BITWIDTH-1:0] rng, rng_r;
  logic [2*BITWIDTH-1:0] tw [NTW];
  logic [(LOG2N+1)*NUMINPUTS-1:0] sr, si;
  logic [NUMINPUTS/2-1:0] vb [LOG2N];
  logic [LOG2N:0] vld;
  logic start, last;
  always_comb begin
    start = state == IDLE && iStart;
    last = state == RUN ? tmr == CW'(CYCLES - 1) : tmr == CW'(LOG2N - 1);
    nxt = state == IDLE ? (iStart ? RUN : IDLE)
        : state == RUN ? (last ? DRAIN : RUN)
        : state == DRAIN ? (last ? DONE : DRAIN) : IDLE;
    rng_r = {rng[BITWIDTH-1-BITWIDTH/2:0], rng[BITWIDTH-1:BITWIDTH-BITWIDTH/2]};
  end
  // outputs are registered from the next state so they line up with the state register
  always_ff @(posedge iClk or negedge iRstN)
    if (!iRstN) begin
      state <= IDLE;
      tmr <= '0;
      cnt <= '0;
      rng <= BITWIDTH'(1);
      oBusy <= 1'b0;
      oDone <= 1'b0;
      oTwReady <= 1'b1;
    end else begin
      state <= nxt;
      tmr <= nxt != state ? '0 : tmr + 1'b1;
      cnt <= start ? 2'd0 : cnt + 2'd1;
      rng <= start ? BITWIDTH'(1) : (state == RUN || state == DRAIN) ? {rng[BITWIDTH-2:0], ^(rng & TAPS)} : rng;
      oBusy <= nxt != IDLE;
      oDone <= nxt == DONE;
      oTwReady <= nxt == IDLE;
    end
  always_ff @(posedge iClk or negedge iRstN)
    if (!iRstN) begin
      for (int k = 0; k < NTW; k++) tw[k] <= '0;
    end else if (iTwValid && oTwReady && int'(iTwAddr) < NTW) begin
      tw[iTwAddr] <= iTwData;
    end
  assign sr[NUMINPUTS-1:0] = iReal;
  assign si[NUMINPUTS-1:0] = iImg;
  assign vld[0] = state == RUN;
  for (genvar s = 0; s < LOG2N; s++) begin : g_stage
    localparam int H = 1 << s;
    assign vld[s+1] = &vb[s];
    for (genvar b = 0; b < NUMINPUTS / 2; b++) begin : g_bfly
      localparam int I = s * NUMINPUTS + (b / H) * 2 * H + b % H;
      localparam int O = I + NUMINPUTS;
      usfft_bfly #(.BITWIDTH(BITWIDTH)) u_bfly (
        .clk(iClk), .rst_n(iRstN), .en(vld[s]), .sel(cnt), .rng(rng), .rng_r(rng_r),
        .tw(tw[tw_addr(s, b, NUMINPUTS)]),
        .x0r(sr[I]), .x0i(si[I]), .x1r(sr[I+H]), .x1i(si[I+H]),
        .y0r(sr[O]), .y0i(si[O]), .y1r(sr[O+H]), .y1i(si[O+H]), .valid(vb[s][b])
      );
    end
  end
  assign oReal = sr[LOG2N*NUMINPUTS +: NUMINPUTS];
  assign oImg = si[LOG2N*NUMINPUTS +: NUMINPUTS];
  always_ff @(posedge iClk or negedge iRstN)
    if (!iRstN || start) begin
      oCntReal <= '0;
      oCntImg <= '0;
    end else if (vld[LOG2N]) begin
      for (int k = 0; k < NUMINPUTS; k++) begin
        if (oReal[k] && oCntReal[k*CW +: CW] != CW'(CYCLES)) oCntReal[k*CW +: CW] <= oCntReal[k*CW +: CW] + 1'b1;
        if (oImg[k] && oCntImg[k*CW +: CW] != CW'(CYCLES)) oCntImg[k*CW +: CW] <= oCntImg[k*CW +: CW] + 1'b1;
      end
    end
endmodule

// File: tb/tb_usfft_stream.sv
// tb_usfft_stream: directed sequence of transforms checked against a frame-level model of the
// bitstream FFT (4 points, 8-bit twiddles, 256-cycle streams).
module tb_usfft_stream;
  logic iClk = 0, iRstN = 1, iStart = 0, iTwValid = 0;
  logic [1:0] iTwAddr = 0;
  logic [15:0] iTwData = 0;
  logic [3:0] iReal = 0, iImg = 0, oReal, oImg;
  logic oTwReady, oBusy, oDone;
  logic [35:0] oCntReal, oCntImg;
  int n_assert = 0, n_fail = 0, pulses = 0;
  logic [15:0] tw_m [4];
  logic [3:0] in_r [256], in_i [256], exp_r [256], exp_i [256];
  logic [35:0] exp_cr, exp_ci;

  usfft_stream #(.BITWIDTH(8), .NUMINPUTS(4), .CYCLES(256)) dut (
    .iClk(iClk), .iRstN(iRstN), .iStart(iStart), .iTwValid(iTwValid), .iTwAddr(iTwAddr),
    .iTwData(iTwData), .iReal(iReal), .iImg(iImg), .oTwReady(oTwReady), .oBusy(oBusy),
    .oDone(oDone), .oReal(oReal), .oImg(oImg), .oCntReal(oCntReal), .oCntImg(oCntImg)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Expected stream per sample: stage s sees sample t with counter (t+s)%4 and the
  // (t+s)-th LFSR value of the transform (seed 1, x^8+x^6+x^5+x^4+1).
  function automatic void model();
    logic [7:0] seq [258];
    logic [7:0] rng, rr;
    logic [3:0] xr, xi, yr, yi;
    logic [15:0] code;
    logic wr, wi, tr, ti;
    int c, h, bf;
    seq[0] = 8'd1;
    for (int k = 1; k < 258; k++) seq[k] = {seq[k-1][6:0], ^(seq[k-1] & 8'hB8)};
    exp_cr = '0;
    exp_ci = '0;
    for (int t = 0; t < 256; t++) begin
      xr = in_r[t];
      xi = in_i[t];
      for (int s = 0; s < 2; s++) begin
        c = (t + s) % 4;
        rng = seq[t+s];
        rr = {rng[3:0], rng[7:4]};
        h = 1 << s;
        bf = 0;
        yr = '0;
        yi = '0;
        for (int i = 0; i < 4; i += 2 * h)
          for (int j = 0; j < h; j++) begin
            code = tw_m[s*2+bf];
            wr = rng < code[7:0];
            wi = rr < code[15:8];
            tr = (c / 2 == 1) ? (xr[i+j+h] == wr) : (xi[i+j+h] != wi);
            ti = (c / 2 == 1) ? (xr[i+j+h] == wi) : (xi[i+j+h] == wr);
            yr[i+j] = (c % 2 == 1) ? xr[i+j] : tr;
            yr[i+j+h] = (c % 2 == 1) ? xr[i+j] : !tr;
            yi[i+j] = (c % 2 == 1) ? xi[i+j] : ti;
            yi[i+j+h] = (c % 2 == 1) ? xi[i+j] : !ti;
            bf++;
          end
        xr = yr;
        xi = yi;
      end
      exp_r[t] = xr;
      exp_i[t] = xi;
      for (int k = 0; k < 4; k++) begin
        exp_cr[k*9 +: 9] = exp_cr[k*9 +: 9] + 9'(xr[k]);
        exp_ci[k*9 +: 9] = exp_ci[k*9 +: 9] + 9'(xi[k]);
      end
    end
  endfunction

  task automatic load_tw();
    chk("twready_load", 64'(oTwReady), 64'd1);
    for (int a = 0; a < 4; a++) begin
      iTwValid = 1;
      iTwAddr = 2'(a);
      iTwData = tw_m[a];
      @(posedge iClk); #1;
    end
    iTwValid = 0;
  endtask

  task automatic rand_inputs();
    for (int t = 0; t < 256; t++) begin
      in_r[t] = 4'($urandom);
      in_i[t] = 4'($urandom);
    end
  endtask

  // Edge e=1 samples iStart; sample t enters on edge t+2 and leaves the last stage after edge t+3.
  task automatic do_run(input bit rep, input bit spam, input bit wr3, input logic [15:0] d3);
    int done_at = 0, np = 0;
    iStart = 1;
    if (wr3) begin
      iTwValid = 1;
      iTwAddr = 2'd3;
      iTwData = d3;
    end
    for (int e = 1; e <= 263; e++) begin
      @(posedge iClk); #1;
      iStart = 0;
      iTwValid = 0;
      if (e >= 3 && e <= 258) chk("stream", 64'({oImg, oReal}), 64'({exp_i[e-3], exp_r[e-3]}));
      if (oDone) begin
        np++;
        if (done_at == 0) done_at = e;
      end
      if (e == 10) begin
        chk("busy_run", 64'(oBusy), 64'd1);
        chk("twready_run", 64'(oTwReady), 64'd0);
      end
      iReal = e <= 256 ? in_r[e-1] : 4'd0;
      iImg = e <= 256 ? in_i[e-1] : 4'd0;
      if (rep && e < 250) iStart = 1'($urandom);
      if (spam && e == 20) begin
        iTwValid = 1;
        iTwAddr = 2'd0;
        iTwData = 16'($urandom);
      end
    end
    chk("done_cycle", 64'(done_at), 64'd259);
    chk("done_pulses", 64'(np), 64'd1);
    chk("busy_end", 64'(oBusy), 64'd0);
    chk("cnt_real", 64'(oCntReal), 64'(exp_cr));
    chk("cnt_img", 64'(oCntImg), 64'(exp_ci));
  endtask

  initial begin
    #1 iRstN = 0;
    repeat (3) @(posedge iClk);
    #1;
    chk("rst_busy", 64'(oBusy), 64'd0);
    chk("rst_stream", 64'({oImg, oReal}), 64'd0);
    iRstN = 1;
    @(posedge iClk); #1;
    chk("idle_twready", 64'(oTwReady), 64'd1);
    chk("idle_busy", 64'(oBusy), 64'd0);
    chk("idle_done", 64'(oDone), 64'd0);
    chk("idle_cnt_real", 64'(oCntReal), 64'd0);
    chk("idle_cnt_img", 64'(oCntImg), 64'd0);
    chk("idle_stream", 64'({oImg, oReal}), 64'd0);
    // DC transform with w ~ 1+0i
    for (int k = 0; k < 4; k++) tw_m[k] = 16'h80FF;
    load_tw();
    for (int t = 0; t < 256; t++) begin
      in_r[t] = 4'hF;
      in_i[t] = t[0] ? 4'hF : 4'h0;
    end
    model();
    do_run(0, 0, 0, 16'd0);
    do_run(1, 0, 0, 16'd0);
    do_run(0, 1, 0, 16'd0);
    do_run(0, 0, 0, 16'd0);
    // write landing in the same cycle as the start request
    rand_inputs();
    tw_m[3] = 16'($urandom);
    model();
    do_run(0, 0, 1, tw_m[3]);
    for (int k = 0; k < 4; k++) tw_m[k] = 16'($urandom);
    load_tw();
    rand_inputs();
    model();
    do_run(0, 0, 0, 16'd0);
    // reset in the middle of a transform
    iStart = 1;
    @(posedge iClk); #1;
    iStart = 0;
    repeat (100) begin
      iReal = 4'($urandom);
      iImg = 4'($urandom);
      @(posedge iClk); #1;
    end
    chk("busy_pre_rst", 64'(oBusy), 64'd1);
    #2 iRstN = 0;
    #1;
    chk("midrst_busy", 64'(oBusy), 64'd0);
    chk("midrst_done", 64'(oDone), 64'd0);
    chk("midrst_stream", 64'({oImg, oReal}), 64'd0);
    chk("midrst_cnt_real", 64'(oCntReal), 64'd0);
    chk("midrst_cnt_img", 64'(oCntImg), 64'd0);
    iReal = 0;
    iImg = 0;
    repeat (3) @(posedge iClk);
    #1 iRstN = 1;
    pulses = 0;
    repeat (300) begin
      @(posedge iClk); #1;
      if (oDone) pulses++;
    end
    chk("no_done_after_rst", 64'(pulses), 64'd0);
    chk("twready_after_rst", 64'(oTwReady), 64'd1);
    // cleared twiddles mean w = -1-1i on every butterfly
    for (int k = 0; k < 4; k++) tw_m[k] = 16'd0;
    rand_inputs();
    model();
    do_run(0, 0, 0, 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
